// File: rtl/alu_issue_stage.sv
// Issue stage in front of a combinational 32-bit ALU: command FIFO feeding the ALU,
// with a registered result/flag stage behind valid/ready handshakes on both sides.
module alu_issue_stage #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [2:0]               cmd_op,
   input  logic [WIDTH-1:0]         cmd_a,
   input  logic [WIDTH-1:0]         cmd_b,
   output logic [2:0]               alu_S,
   output logic [WIDTH-1:0]         alu_A,
   output logic [WIDTH-1:0]         alu_B,
   input  logic [WIDTH-1:0]         alu_out,
   input  logic                     alu_zero,
   input  logic                     alu_overflow,
   input  logic                     alu_cout,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [WIDTH-1:0]         res_data,
   output logic                     res_zero,
   output logic                     res_overflow,
   output logic                     res_cout,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [2:0]       op_mem [DEPTH];
   logic [WIDTH-1:0] a_mem  [DEPTH];
   logic [WIDTH-1:0] b_mem  [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             push, issue, not_empty;

   assign not_empty = (count != '0);
   assign cmd_ready = (count < FULL);
   assign push      = cmd_valid && cmd_ready;
   assign issue     = not_empty && (!res_valid || res_ready);

   assign alu_S = not_empty ? op_mem[rd_ptr] : 3'd0;
   assign alu_A = not_empty ? a_mem[rd_ptr]  : '0;
   assign alu_B = not_empty ? b_mem[rd_ptr]  : '0;

   // Storage has no reset; a reset cycle must still not accept a command.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         op_mem[wr_ptr] <= cmd_op;
         a_mem[wr_ptr]  <= cmd_a;
         b_mem[wr_ptr]  <= cmd_b;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)  wr_ptr <= wr_ptr + 1'b1;
         if (issue) rd_ptr <= rd_ptr + 1'b1;
         case ({push, issue})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         res_valid    <= 1'b0;
         res_data     <= '0;
         res_zero     <= 1'b0;
         res_overflow <= 1'b0;
         res_cout     <= 1'b0;
      end else if (issue) begin
         res_valid    <= 1'b1;
         res_data     <= alu_out;
         res_zero     <= alu_zero;
         res_overflow <= alu_overflow;
         res_cout     <= alu_cout;
      end else if (res_valid && res_ready) begin
         res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural combinational ALU on the alu_* side.
module tb_alu_issue_stage;

   localparam int DEPTH = 4;
   localparam int WIDTH = 32;
   localparam logic [2:0] OP_ADD = 3'd2;

   logic             clk = 1'b0;
   logic             reset;
   logic             cmd_valid, cmd_ready;
   logic [2:0]       cmd_op;
   logic [WIDTH-1:0] cmd_a, cmd_b;
   logic [2:0]       alu_S;
   logic [WIDTH-1:0] alu_A, alu_B, alu_out;
   logic             alu_zero, alu_overflow, alu_cout;
   logic             res_valid, res_ready;
   logic [WIDTH-1:0] res_data;
   logic             res_zero, res_overflow, res_cout;
   logic [2:0]       count;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   alu_issue_stage #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_S(alu_S), .alu_A(alu_A), .alu_B(alu_B),
      .alu_out(alu_out), .alu_zero(alu_zero),
      .alu_overflow(alu_overflow), .alu_cout(alu_cout),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_zero(res_zero),
      .res_overflow(res_overflow), .res_cout(res_cout),
      .count(count)
   );

   // Reference ALU: 0 AND, 1 OR, 2 ADD, 6 SUB, anything else XOR.
   logic [WIDTH:0] sum_ext;
   always_comb begin
      sum_ext      = '0;
      alu_out      = '0;
      alu_overflow = 1'b0;
      alu_cout     = 1'b0;
      case (alu_S)
         3'd0: alu_out = alu_A & alu_B;
         3'd1: alu_out = alu_A | alu_B;
         3'd2: begin
            sum_ext      = {1'b0, alu_A} + {1'b0, alu_B};
            alu_out      = sum_ext[WIDTH-1:0];
            alu_cout     = sum_ext[WIDTH];
            alu_overflow = (alu_A[WIDTH-1] == alu_B[WIDTH-1]) &&
                           (alu_out[WIDTH-1] != alu_A[WIDTH-1]);
         end
         3'd6: begin
            sum_ext      = {1'b0, alu_A} + {1'b0, ~alu_B} + 1'b1;
            alu_out      = sum_ext[WIDTH-1:0];
            alu_cout     = sum_ext[WIDTH];
            alu_overflow = (alu_A[WIDTH-1] != alu_B[WIDTH-1]) &&
                           (alu_out[WIDTH-1] != alu_A[WIDTH-1]);
         end
         default: alu_out = alu_A ^ alu_B;
      endcase
      alu_zero = (alu_out == '0);
   end

   // Inputs change and outputs are sampled on the falling edge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [2:0] op,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      cmd_valid = v;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
   endtask

   task automatic test_reset();
      reset = 1'b1; res_ready = 1'b0;
      drive(1'b0, 3'd0, '0, '0);
      cyc(); cyc();
      reset = 1'b0;
      vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
      vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
      vectors++; if (res_data !== 32'd0) begin miscompares++; $display("FAIL reset_res_data got %h want 0", res_data); end
      vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
      vectors++; if ({alu_S, alu_A, alu_B} !== 67'd0) begin miscompares++; $display("FAIL reset_alu_drive got %h/%h/%h want 0", alu_S, alu_A, alu_B); end
   endtask

   task automatic test_single(input string tag);
      res_ready = 1'b1;
      drive(1'b1, OP_ADD, 32'd5, 32'd7);
      cyc();
      drive(1'b0, 3'd0, '0, '0);
      vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL %s_count_after_push got %0d want 1", tag, count); end
      vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL %s_early_valid got %b want 0", tag, res_valid); end
      vectors++; if (alu_A !== 32'd5 || alu_B !== 32'd7 || alu_S !== OP_ADD) begin miscompares++; $display("FAIL %s_head_drive got %h/%h/%h want 2/5/7", tag, alu_S, alu_A, alu_B); end
      cyc();
      vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL %s_valid got %b want 1", tag, res_valid); end
      vectors++; if (res_data !== 32'd12) begin miscompares++; $display("FAIL %s_data got %0d want 12", tag, res_data); end
      vectors++; if ({res_zero, res_overflow, res_cout} !== 3'b000) begin miscompares++; $display("FAIL %s_flags got %b want 000", tag, {res_zero, res_overflow, res_cout}); end
      vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL %s_count_after_issue got %0d want 0", tag, count); end
      cyc();
      vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL %s_valid_drop got %b want 0", tag, res_valid); end
      vectors++; if (res_data !== 32'd12) begin miscompares++; $display("FAIL %s_data_hold got %0d want 12", tag, res_data); end
   endtask

   task automatic test_flags();
      res_ready = 1'b1;
      drive(1'b1, OP_ADD, 32'h7FFF_FFFF, 32'd1);
      cyc();
      drive(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'd1);
      cyc();
      drive(1'b0, 3'd0, '0, '0);
      vectors++; if (res_data !== 32'h8000_0000) begin miscompares++; $display("FAIL ovf_data got %h want 80000000", res_data); end
      vectors++; if ({res_zero, res_overflow, res_cout} !== 3'b010) begin miscompares++; $display("FAIL ovf_flags got %b want 010", {res_zero, res_overflow, res_cout}); end
      cyc();
      vectors++; if (res_data !== 32'd0) begin miscompares++; $display("FAIL carry_data got %h want 0", res_data); end
      vectors++; if ({res_zero, res_overflow, res_cout} !== 3'b101) begin miscompares++; $display("FAIL carry_flags got %b want 101", {res_zero, res_overflow, res_cout}); end
      cyc();
      vectors++; if (res_valid !== 1'b0 || count !== 3'd0) begin miscompares++; $display("FAIL flags_idle got valid=%b count=%0d want 0/0", res_valid, count); end
   endtask

   // Command i is ADD (100+i) + i, so its result is 100 + 2i.
   task automatic test_backpressure();
      res_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, OP_ADD, 32'(100 + i), 32'(i));
         cyc();
      end
      vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL full_count got %0d want 4", count); end
      vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL full_cmd_ready got %b want 0", cmd_ready); end
      vectors++; if (res_valid !== 1'b1 || res_data !== 32'd100) begin miscompares++; $display("FAIL full_result got valid=%b data=%0d want 1/100", res_valid, res_data); end
      drive(1'b1, OP_ADD, 32'd999, 32'd999);
      cyc();
      cyc();
      drive(1'b0, 3'd0, '0, '0);
      vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL sixth_push_count got %0d want 4", count); end
      vectors++; if (res_valid !== 1'b1 || res_data !== 32'd100) begin miscompares++; $display("FAIL held_result got valid=%b data=%0d want 1/100", res_valid, res_data); end
   endtask

   task automatic test_drain();
      res_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         cyc();
         vectors++; if (res_valid !== 1'b1 || res_data !== 32'(100 + 2*i)) begin miscompares++; $display("FAIL drain_%0d got valid=%b data=%0d want 1/%0d", i, res_valid, res_data, 100 + 2*i); end
         vectors++; if (count !== 3'(4 - i)) begin miscompares++; $display("FAIL drain_count_%0d got %0d want %0d", i, count, 4 - i); end
      end
      cyc();
      vectors++; if (res_valid !== 1'b0 || count !== 3'd0) begin miscompares++; $display("FAIL drain_end got valid=%b count=%0d want 0/0", res_valid, count); end
      vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL drain_cmd_ready got %b want 1", cmd_ready); end
   endtask

   // Command j is ADD 3j + 1000; with both sides open the result lags by one edge.
   task automatic test_back_to_back();
      res_ready = 1'b1;
      for (int j = 0; j < 10; j++) begin
         drive(1'b1, OP_ADD, 32'(3*j), 32'd1000);
         cyc();
         vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL stream_count_%0d got %0d want 1", j, count); end
         if (j > 0) begin
            vectors++; if (res_valid !== 1'b1 || res_data !== 32'(1000 + 3*(j-1))) begin miscompares++; $display("FAIL stream_%0d got valid=%b data=%0d want 1/%0d", j, res_valid, res_data, 1000 + 3*(j-1)); end
         end
      end
      drive(1'b0, 3'd0, '0, '0);
      cyc();
      vectors++; if (res_valid !== 1'b1 || res_data !== 32'd1027 || count !== 3'd0) begin miscompares++; $display("FAIL stream_last got valid=%b data=%0d count=%0d want 1/1027/0", res_valid, res_data, count); end
      cyc();
      vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL stream_idle got %b want 0", res_valid); end
   endtask

   task automatic test_reset_mid();
      res_ready = 1'b0;
      drive(1'b1, OP_ADD, 32'd1, 32'd2);          cyc();
      drive(1'b1, 3'd7,   32'h0000_00F0, 32'h0F); cyc();
      drive(1'b1, OP_ADD, 32'd3, 32'd4);          cyc();
      drive(1'b1, OP_ADD, 32'd5, 32'd6);          cyc();
      drive(1'b0, 3'd0, '0, '0);
      vectors++; if (count !== 3'd3 || res_valid !== 1'b1 || res_data !== 32'd3) begin miscompares++; $display("FAIL pre_reset got count=%0d valid=%b data=%0d want 3/1/3", count, res_valid, res_data); end
      vectors++; if (alu_S !== 3'd7 || alu_A !== 32'h0000_00F0) begin miscompares++; $display("FAIL undef_op_head got S=%0d A=%h want 7/f0", alu_S, alu_A); end
      reset = 1'b1; res_ready = 1'b1;
      drive(1'b1, OP_ADD, 32'd50, 32'd50);
      cyc();
      reset = 1'b0;
      drive(1'b0, 3'd0, '0, '0);
      vectors++; if (count !== 3'd0 || res_valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_state got count=%0d valid=%b want 0/0", count, res_valid); end
      vectors++; if (res_data !== 32'd0 || cmd_ready !== 1'b1) begin miscompares++; $display("FAIL mid_reset_out got data=%0d ready=%b want 0/1", res_data, cmd_ready); end
      cyc();
      vectors++; if (count !== 3'd0 || res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_push_leak got count=%0d valid=%b want 0/0", count, res_valid); end
      test_single("post_reset");
   endtask

   initial begin
      test_reset();
      test_single("single");
      test_flags();
      test_backpressure();
      test_drain();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
